// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard-control signals between the pipeline top level and the sequencer.
// The master side drives the stage/hazard inputs. The slave side returns the freeze/flush controls and the statistics.
interface pipe_hazard_ctrl_if #(
   parameter int REG_W = 4,
   parameter int CNT_W = 16
);
   logic             forward_en;
   logic [REG_W-1:0] src1;
   logic [REG_W-1:0] src2;
   logic             two_src;
   logic             exe_wb_en;
   logic [REG_W-1:0] exe_dest;
   logic             exe_mem_read;
   logic             mem_wb_en;
   logic [REG_W-1:0] mem_dest;
   logic             branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             clr_stats;
   logic             if_freeze;
   logic             if_flush;
   logic             id_flush;
   logic             pipe_freeze;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output forward_en, src1, src2, two_src, exe_wb_en, exe_dest, exe_mem_read,
             mem_wb_en, mem_dest, branch_taken, mem_req, mem_ready, clr_stats,
      input  if_freeze, if_flush, id_flush, pipe_freeze, mem_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  forward_en, src1, src2, two_src, exe_wb_en, exe_dest, exe_mem_read,
             mem_wb_en, mem_dest, branch_taken, mem_req, mem_ready, clr_stats,
      output if_freeze, if_flush, id_flush, pipe_freeze, mem_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: freeze/flush arbitration (memory wait > branch > RAW hazard), wait timeout, stall/flush stats.
// Controls are combinational (zero latency); the FSM, timeout flag and counters update on the rising edge of clk.
module pipe_hazard_ctrl #(
   parameter int REG_W       = 4,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   pipe_hazard_ctrl_if.slave   bus
);
   localparam logic [0:0]       ST_RUN      = 1'b0;
   localparam logic [0:0]       ST_MEM_WAIT = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TMO_LIMIT   = CNT_W'(MEM_TIMEOUT);

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_mem_timeout;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic             w_s1_exe;
   logic             w_s2_exe;
   logic             w_s1_mem;
   logic             w_s2_mem;
   logic             w_hz;
   logic             w_mw;
   logic [CNT_W-1:0] w_wait_nxt;
   logic             w_if_freeze;
   logic             w_if_flush;
   logic             w_id_flush;
   logic             w_pipe_freeze;

   assign w_s1_exe = (bus.src1 == bus.exe_dest);
   assign w_s2_exe = bus.two_src & (bus.src2 == bus.exe_dest);
   assign w_s1_mem = (bus.src1 == bus.mem_dest);
   assign w_s2_mem = bus.two_src & (bus.src2 == bus.mem_dest);

   // With forwarding only a load in EXE cannot be bypassed in time.
   assign w_hz = bus.forward_en ? (bus.exe_mem_read & (w_s1_exe | w_s2_exe))
                                : ((bus.exe_wb_en & (w_s1_exe | w_s2_exe)) |
                                   (bus.mem_wb_en & (w_s1_mem | w_s2_mem)));

   assign w_mw = bus.mem_req & ~bus.mem_ready;

   always_comb begin
      w_if_freeze   = 1'b0;
      w_if_flush    = 1'b0;
      w_id_flush    = 1'b0;
      w_pipe_freeze = 1'b0;
      if (rst) begin
         if (w_mw) begin
            w_if_freeze   = 1'b1;
            w_pipe_freeze = 1'b1;
         end else if (bus.branch_taken) begin
            w_if_flush = 1'b1;
            w_id_flush = 1'b1;
         end else if (w_hz) begin
            w_if_freeze = 1'b1;
            w_id_flush  = 1'b1;
         end
      end
   end

   assign w_wait_nxt = (r_state == ST_RUN)      ? CNT_ONE :
                       (r_wait_cnt == CNT_MAX) ? CNT_MAX : r_wait_cnt + CNT_ONE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         if (w_mw) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt >= TMO_LIMIT) begin
               r_mem_timeout <= 1'b1;
            end
         end else begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (bus.clr_stats) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_if_freeze && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         end
         if (w_if_flush && (r_flush_cnt != CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + CNT_ONE;
         end
      end
   end

   assign bus.if_freeze   = w_if_freeze;
   assign bus.if_flush    = w_if_flush;
   assign bus.id_flush    = w_id_flush;
   assign bus.pipe_freeze = w_pipe_freeze;
   assign bus.mem_timeout = r_mem_timeout;
   assign bus.stall_cnt   = r_stall_cnt;
   assign bus.flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed steps followed by randomized traffic.
// All results are checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
   localparam int REG_W   = 4;
   localparam int CNT_W   = 4;
   localparam int TMO     = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   int   m_consec;
   bit   m_timeout;
   int   m_stall;
   int   m_flush;
   bit   last_frz;
   bit   last_fls;

   pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) ifc ();

   pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit reads(input logic [REG_W-1:0] d);
      return (ifc.src1 == d) || (ifc.two_src && (ifc.src2 == d));
   endfunction

   // Control outputs from the priority rules: memory wait, then branch, then RAW hazard.
   task automatic model_comb(output bit fz, output bit ff, output bit idf, output bit pf);
      bit hz;
      bit mw;
      fz = 0; ff = 0; idf = 0; pf = 0;
      hz = 0;
      if (ifc.forward_en) begin
         if (ifc.exe_mem_read && reads(ifc.exe_dest)) hz = 1;
      end else begin
         if (ifc.exe_wb_en && reads(ifc.exe_dest)) hz = 1;
         if (ifc.mem_wb_en && reads(ifc.mem_dest)) hz = 1;
      end
      mw = ifc.mem_req && !ifc.mem_ready;
      if (rst) begin
         if (mw) begin
            fz = 1; pf = 1;
         end else if (ifc.branch_taken) begin
            ff = 1; idf = 1;
         end else if (hz) begin
            fz = 1; idf = 1;
         end
      end
   endtask

   task automatic model_clock();
      bit fz, ff, idf, pf;
      if (rst) begin
         model_comb(fz, ff, idf, pf);
         if (ifc.mem_req && !ifc.mem_ready) m_consec++;
         else m_consec = 0;
         if (m_consec >= TMO) m_timeout = 1;
         if (ifc.clr_stats) begin
            m_stall = 0;
            m_flush = 0;
         end else begin
            if (fz && m_stall < CNT_MAX) m_stall++;
            if (ff && m_flush < CNT_MAX) m_flush++;
         end
      end
   endtask

   task automatic model_reset();
      m_consec = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".mem_timeout"}, 16'(ifc.mem_timeout), 16'(m_timeout));
      chk({tag, ".stall_cnt"},   16'(ifc.stall_cnt),   16'(m_stall));
      chk({tag, ".flush_cnt"},   16'(ifc.flush_cnt),   16'(m_flush));
   endtask

   task automatic check_comb(input string tag);
      bit fz, ff, idf, pf;
      model_comb(fz, ff, idf, pf);
      chk({tag, ".if_freeze"},   16'(ifc.if_freeze),   16'(fz));
      chk({tag, ".if_flush"},    16'(ifc.if_flush),    16'(ff));
      chk({tag, ".id_flush"},    16'(ifc.id_flush),    16'(idf));
      chk({tag, ".pipe_freeze"}, 16'(ifc.pipe_freeze), 16'(pf));
   endtask

   // Inputs are set at posedge+1; combinational outputs are checked mid-cycle, state after the edge.
   task automatic tick(input string tag);
      #3;
      check_comb(tag);
      last_frz = ifc.if_freeze;
      last_fls = ifc.if_flush;
      @(posedge clk);
      model_clock();
      #1;
      check_regs(tag);
   endtask

   task automatic idle_inputs();
      ifc.forward_en = 0; ifc.src1 = '0; ifc.src2 = '0; ifc.two_src = 0;
      ifc.exe_wb_en = 0; ifc.exe_dest = '0; ifc.exe_mem_read = 0;
      ifc.mem_wb_en = 0; ifc.mem_dest = '0; ifc.branch_taken = 0;
      ifc.mem_req = 0; ifc.mem_ready = 0; ifc.clr_stats = 0;
   endtask

   initial begin
      int n_frz;
      int n_fls;
      bit fls_last;
      n_vec = 0; n_err = 0;
      model_reset();
      rst = 1'b0;
      idle_inputs();
      // Reset with a wait request and branch pending: controls must stay low.
      ifc.mem_req = 1; ifc.branch_taken = 1;
      #1;
      check_comb("reset_ctrl");
      check_regs("reset_regs");
      @(posedge clk); #1;
      rst = 1'b1;
      idle_inputs();
      tick("idle");

      // RAW hazard without forwarding, then the same with forwarding and no load.
      ifc.exe_wb_en = 1; ifc.exe_dest = 4'd3; ifc.src1 = 4'd3; ifc.src2 = 4'd9;
      tick("raw_nofwd");
      chk("raw_nofwd_freeze_const", 16'(last_frz), 16'd1);
      ifc.forward_en = 1; ifc.exe_mem_read = 0;
      tick("raw_fwd");
      chk("raw_fwd_freeze_const", 16'(last_frz), 16'd0);

      // Stats clear, then load-use through src2.
      idle_inputs(); ifc.clr_stats = 1;
      tick("clr");
      idle_inputs();
      ifc.forward_en = 1; ifc.exe_mem_read = 1; ifc.exe_wb_en = 1; ifc.exe_dest = 4'd5;
      ifc.two_src = 1; ifc.src1 = 4'd1; ifc.src2 = 4'd5;
      tick("load_use");
      chk("load_use_stall_const", 16'(ifc.stall_cnt), 16'd1);
      idle_inputs();
      tick("after_bubble");

      // Branch over a live hazard.
      ifc.exe_wb_en = 1; ifc.exe_dest = 4'd7; ifc.src1 = 4'd7; ifc.branch_taken = 1;
      tick("branch_hz");
      chk("branch_flush_cnt_const", 16'(ifc.flush_cnt), 16'd1);
      idle_inputs();

      // Four wait cycles with a branch held; the branch lands on cycle 5.
      n_frz = 0; n_fls = 0; fls_last = 0;
      ifc.branch_taken = 1; ifc.mem_req = 1; ifc.mem_ready = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) ifc.mem_ready = 1;
         tick("mw4");
         n_frz += int'(last_frz);
         n_fls += int'(last_fls);
         if (i == 4) fls_last = last_fls;
      end
      chk("mw4_freeze_cycles", 16'(n_frz), 16'd4);
      chk("mw4_branch_count", 16'(n_fls), 16'd1);
      chk("mw4_branch_on_c5", 16'(fls_last), 16'd1);
      idle_inputs();
      tick("mw4_done");

      // Timeout: sets after the 8th consecutive wait cycle and stays set.
      ifc.mem_req = 1; ifc.mem_ready = 0;
      for (int i = 1; i <= 10; i++) begin
         tick("tmo_wait");
         chk("tmo_flag_const", 16'(ifc.mem_timeout), 16'((i >= TMO) ? 1 : 0));
      end
      ifc.mem_ready = 1;
      for (int i = 0; i < 3; i++) tick("tmo_sticky");
      chk("tmo_sticky_const", 16'(ifc.mem_timeout), 16'd1);

      // Stall counter saturation, clear taking precedence over increment.
      idle_inputs(); ifc.clr_stats = 1;
      tick("sat_clr");
      ifc.clr_stats = 0; ifc.mem_req = 1; ifc.mem_ready = 0;
      for (int i = 0; i < 20; i++) tick("sat_wait");
      chk("sat_stall_const", 16'(ifc.stall_cnt), 16'(CNT_MAX));
      ifc.clr_stats = 1;
      tick("sat_clr_mid");
      chk("clr_mid_const", 16'(ifc.stall_cnt), 16'd0);
      chk("clr_keeps_tmo", 16'(ifc.mem_timeout), 16'd1);
      ifc.clr_stats = 0;
      tick("sat_resume");

      // Asynchronous reset in the middle of a wait.
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_comb("arst_ctrl");
      check_regs("arst_regs");
      @(posedge clk); #1;
      rst = 1'b1;
      idle_inputs();
      tick("post_arst");

      // Randomized traffic: a mixed phase, then a phase of long memory waits.
      for (int i = 0; i < 600; i++) begin
         ifc.forward_en   = 1'($urandom_range(0, 1));
         ifc.src1         = REG_W'($urandom_range(0, 3));
         ifc.src2         = REG_W'($urandom_range(0, 3));
         ifc.two_src      = 1'($urandom_range(0, 1));
         ifc.exe_wb_en    = 1'($urandom_range(0, 1));
         ifc.exe_dest     = REG_W'($urandom_range(0, 3));
         ifc.exe_mem_read = 1'($urandom_range(0, 1));
         ifc.mem_wb_en    = 1'($urandom_range(0, 1));
         ifc.mem_dest     = REG_W'($urandom_range(0, 3));
         ifc.branch_taken = ($urandom_range(0, 5) == 0);
         ifc.mem_req      = ($urandom_range(0, 2) == 0) || (i >= 300);
         ifc.mem_ready    = (i < 300) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 11) == 0);
         ifc.clr_stats    = ($urandom_range(0, 40) == 0);
         tick("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end
endmodule
